// File: rtl/mesh_pkg.sv
// Shared constants for the mesh result drain path: word width, default column
// height and the clog2 helper used to size the row index.
package mesh_pkg;

  localparam int WORD_W         = 8;
  localparam int N_ROWS_DEFAULT = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mesh_result_bank.sv
// Two-bank ping-pong store for captured mesh waves: write/read pointers,
// occupancy count, free-slot decision and the sticky overrun flag.
module mesh_result_bank
  import mesh_pkg::*;
#(
  parameter int N_ROWS = N_ROWS_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cap_i,
  input  logic [N_ROWS*WORD_W-1:0] data_i,
  input  logic                     pop_last_i,
  output logic [N_ROWS*WORD_W-1:0] rd_data_o,
  output logic [1:0]               count_o,
  output logic                     ovr_o
);

  logic [N_ROWS*WORD_W-1:0] bank_q [2];
  logic                     wp_q;
  logic                     rp_q;
  logic [1:0]               count_q;
  logic [1:0]               count_d;
  logic                     ovr_q;
  logic                     free;
  logic                     accept;

  // A full store still has room when the head wave retires on this same edge.
  always_comb begin
    free    = (count_q != 2'd2) || pop_last_i;
    accept  = cap_i && free;
    count_d = count_q + {1'b0, accept} - {1'b0, pop_last_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      count_q   <= 2'd0;
      ovr_q     <= 1'b0;
    end else begin
      if (accept) begin
        bank_q[wp_q] <= data_i;
        wp_q         <= ~wp_q;
      end
      if (pop_last_i) rp_q <= ~rp_q;
      if (cap_i && !free) ovr_q <= 1'b1;
      count_q <= count_d;
    end
  end

  assign rd_data_o = bank_q[rp_q];
  assign count_o   = count_q;
  assign ovr_o     = ovr_q;

endmodule

// File: rtl/mesh_result_drain.sv
// Serialises captured mesh column results over a valid/ready stream.
// Define MESH_DRAIN_CHKSUM_EN to append a per-wave modulo-256 checksum word.
module mesh_result_drain
  import mesh_pkg::*;
#(
  parameter int N_ROWS = N_ROWS_DEFAULT,
  parameter int IDX_W  = clog2(N_ROWS + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CAP,
  input  logic [N_ROWS*WORD_W-1:0] MTX_IN,
  output logic [WORD_W-1:0]        OUT_DATA,
  output logic [IDX_W-1:0]         OUT_IDX,
  output logic                     OUT_LAST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     BUSY,
  output logic                     OVR
);

`ifdef MESH_DRAIN_CHKSUM_EN
  localparam int LAST_IDX = N_ROWS;
`else
  localparam int LAST_IDX = N_ROWS - 1;
`endif

  logic [N_ROWS*WORD_W-1:0] rd_data;
  logic [1:0]               count;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         idx_d;
  logic                     valid;
  logic                     xfer;
  logic                     at_last;
  logic                     pop_last;
  logic [WORD_W-1:0]        row_word;
  logic [WORD_W-1:0]        chk_sum;

  mesh_result_bank #(
    .N_ROWS(N_ROWS)
  ) u_bank (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .cap_i     (CAP),
    .data_i    (MTX_IN),
    .pop_last_i(pop_last),
    .rd_data_o (rd_data),
    .count_o   (count),
    .ovr_o     (OVR)
  );

  always_comb begin
    valid    = (count != 2'd0);
    xfer     = valid && OUT_READY;
    at_last  = (idx_q == IDX_W'(LAST_IDX));
    pop_last = xfer && at_last;
    idx_d    = idx_q;
    if (xfer) idx_d = at_last ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    row_word = '0;
    chk_sum  = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (idx_q == IDX_W'(r)) row_word = rd_data[r*WORD_W +: WORD_W];
      chk_sum = chk_sum + rd_data[r*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) idx_q <= '0;
    else      idx_q <= idx_d;
  end

  // Everything below is a pure mux of registered state; OUT_READY only steers idx_d.
`ifdef MESH_DRAIN_CHKSUM_EN
  assign OUT_DATA = (idx_q == IDX_W'(N_ROWS)) ? chk_sum : row_word;
`else
  assign OUT_DATA = row_word;
`endif
  assign OUT_IDX   = idx_q;
  assign OUT_LAST  = valid && at_last;
  assign OUT_VALID = valid;
  assign BUSY      = valid;

endmodule
